leiwand_rv32_mem_arbiter: RTL and testbench

LEIWAND_RV32_MEM_ARBITER -- requirements
Module: leiwand_rv32_mem_arbiter

---
 rtl/leiwand_rv32_mem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_leiwand_rv32_mem_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/leiwand_rv32_mem_arbiter.sv
// -----------------------------------------------------------------------------
// leiwand_rv32_mem_arbiter
//
// Two-master, one-slave memory bus arbiter for the RV32 core complex.
// Masters are served round-robin when both request in the same cycle. The
// request fields of the granted master are passed through to the slave
// combinationally, and the slave response goes back the same way. A wait
// counter aborts a transfer whose slave never answers.
//
// Ports
//   i_clk, i_rst           clock (rising edge), asynchronous active-low reset
//   i_mN_valid             master N request, held until o_mN_ready
//   o_mN_ready             master N transfer complete (normal or aborted)
//   o_mN_err               master N transfer aborted by timeout (with ready)
//   i_mN_addr/wdata/wen    master N address, write data, byte write enables
//   o_mN_rdata             master N read data (all ones on abort)
//   o_s_valid ... i_s_rdata shared slave bus
// -----------------------------------------------------------------------------
module leiwand_rv32_mem_arbiter #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                i_clk,
    input  logic                i_rst,

    input  logic                i_m0_valid,
    output logic                o_m0_ready,
    output logic                o_m0_err,
    input  logic [XLEN-1:0]     i_m0_addr,
    input  logic [XLEN-1:0]     i_m0_wdata,
    input  logic [XLEN/8-1:0]   i_m0_wen,
    output logic [XLEN-1:0]     o_m0_rdata,

    input  logic                i_m1_valid,
    output logic                o_m1_ready,
    output logic                o_m1_err,
    input  logic [XLEN-1:0]     i_m1_addr,
    input  logic [XLEN-1:0]     i_m1_wdata,
    input  logic [XLEN/8-1:0]   i_m1_wen,
    output logic [XLEN-1:0]     o_m1_rdata,

    output logic                o_s_valid,
    input  logic                i_s_ready,
    output logic [XLEN-1:0]     o_s_addr,
    output logic [XLEN-1:0]     o_s_wdata,
    output logic [XLEN/8-1:0]   o_s_wen,
    input  logic [XLEN-1:0]     i_s_rdata
);

    localparam int WEN_W = XLEN / 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GRANT0 = 2'd1;
    localparam logic [1:0] ST_GRANT1 = 2'd2;

    // The abort fires on the TIMEOUT-th wait cycle; the counter is 0 in the
    // first grant cycle, so that is the cycle where it holds TIMEOUT-1.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    logic [1:0] state_reg, state_next;
    logic       last_grant_reg, last_grant_next;
    logic [7:0] wait_cnt_reg, wait_cnt_next;
    // Cleared by reset, set on the first edge after release: IDLE may only
    // grant from the second edge on.
    logic       armed_reg;

    // Per-master views of the ports so both masters share one code path.
    logic [1:0]      m_valid;
    logic [XLEN-1:0] m_addr  [2];
    logic [XLEN-1:0] m_wdata [2];
    logic [WEN_W-1:0] m_wen  [2];
    logic [1:0]      m_ready;
    logic [1:0]      m_err;
    logic [XLEN-1:0] m_rdata [2];

    logic [1:0] granted;
    logic       in_grant;
    logic       cur;
    logic       cur_valid;
    logic       timeout_hit;

    assign m_valid    = {i_m1_valid, i_m0_valid};
    assign m_addr[0]  = i_m0_addr;
    assign m_addr[1]  = i_m1_addr;
    assign m_wdata[0] = i_m0_wdata;
    assign m_wdata[1] = i_m1_wdata;
    assign m_wen[0]   = i_m0_wen;
    assign m_wen[1]   = i_m1_wen;

    assign granted   = {state_reg == ST_GRANT1, state_reg == ST_GRANT0};
    assign in_grant  = |granted;
    assign cur       = granted[1];
    assign cur_valid = m_valid[cur];

    // A slave ready in the same cycle wins over the abort.
    assign timeout_hit = in_grant & cur_valid & ~i_s_ready & (wait_cnt_reg == WAIT_LAST);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_master
            assign m_ready[gi] = granted[gi] & (i_s_ready | timeout_hit);
            assign m_err[gi]   = granted[gi] & timeout_hit;
            assign m_rdata[gi] = !granted[gi] ? '0 :
                                 (timeout_hit ? {XLEN{1'b1}} : i_s_rdata);
        end
    endgenerate

    assign o_m0_ready = m_ready[0];
    assign o_m0_err   = m_err[0];
    assign o_m0_rdata = m_rdata[0];
    assign o_m1_ready = m_ready[1];
    assign o_m1_err   = m_err[1];
    assign o_m1_rdata = m_rdata[1];

    assign o_s_valid = in_grant & cur_valid & ~timeout_hit;
    assign o_s_addr  = in_grant ? m_addr[cur]  : '0;
    assign o_s_wdata = in_grant ? m_wdata[cur] : '0;
    assign o_s_wen   = in_grant ? m_wen[cur]   : '0;

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        wait_cnt_next   = wait_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                wait_cnt_next = '0;
                if (armed_reg) begin
                    if (m_valid == 2'b11) begin
                        state_next = last_grant_reg ? ST_GRANT0 : ST_GRANT1;
                    end else if (m_valid[0]) begin
                        state_next = ST_GRANT0;
                    end else if (m_valid[1]) begin
                        state_next = ST_GRANT1;
                    end
                end
            end
            ST_GRANT0, ST_GRANT1: begin
                if (!cur_valid) begin
                    // Requester withdrew: no one was served, fairness unchanged.
                    state_next = ST_IDLE;
                end else if (i_s_ready || timeout_hit) begin
                    // An aborted transfer still counts as served for fairness,
                    // so a dead slave cannot starve the other master.
                    state_next      = ST_IDLE;
                    last_grant_next = cur;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 8'd1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_reg      <= ST_IDLE;
            last_grant_reg <= 1'b1;
            wait_cnt_reg   <= '0;
            armed_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            wait_cnt_reg   <= wait_cnt_next;
            armed_reg      <= 1'b1;
        end
    end

endmodule

// File: tb/tb_leiwand_rv32_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_leiwand_rv32_mem_arbiter
//
// Directed scenarios (reset, single master read, write pass-through, timeout,
// ready-vs-timeout, reset mid-transfer, round-robin contention) followed by
// randomized master/slave traffic. A transaction-level reference model
// tracks who owns the bus and predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_leiwand_rv32_mem_arbiter;

    localparam int XLEN = 32;
    localparam int TO   = 4;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        mv   [2];
    logic [31:0] ma   [2];
    logic [31:0] mw   [2];
    logic [3:0]  mwen [2];
    logic        mr   [2];
    logic        me   [2];
    logic [31:0] mrd  [2];
    logic        s_valid;
    logic        sr;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wen;
    logic [31:0] srd;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: bus owner (-1 = nobody), wait cycles spent in the
    // current grant, master served last, edges seen since reset release.
    int owner;
    int waited;
    int last_g;
    int since_rel;
    bit done_m [2];

    leiwand_rv32_mem_arbiter #(.XLEN(XLEN), .TIMEOUT(TO)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_m0_valid (mv[0]),
        .o_m0_ready (mr[0]),
        .o_m0_err   (me[0]),
        .i_m0_addr  (ma[0]),
        .i_m0_wdata (mw[0]),
        .i_m0_wen   (mwen[0]),
        .o_m0_rdata (mrd[0]),
        .i_m1_valid (mv[1]),
        .o_m1_ready (mr[1]),
        .o_m1_err   (me[1]),
        .i_m1_addr  (ma[1]),
        .i_m1_wdata (mw[1]),
        .i_m1_wen   (mwen[1]),
        .o_m1_rdata (mrd[1]),
        .o_s_valid  (s_valid),
        .i_s_ready  (sr),
        .o_s_addr   (s_addr),
        .o_s_wdata  (s_wdata),
        .o_s_wen    (s_wen),
        .i_s_rdata  (srd)
    );

    initial forever #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // ---------------- reference model, evaluated mid-cycle ----------------
    initial begin
        logic        to_hit;
        logic        e_sv;
        logic [31:0] e_sa, e_sw, e_rd;
        logic [3:0]  e_swen;
        logic        gr;
        owner = -1; last_g = 1; waited = 0; since_rel = 0;
        forever begin
            @(negedge i_clk);
            if (!i_rst) begin
                owner = -1; last_g = 1; waited = 0; since_rel = 0;
            end
            to_hit = 1'b0; e_sv = 1'b0; e_sa = '0; e_sw = '0; e_swen = '0;
            if (owner >= 0) begin
                // Abort on the TO-th cycle spent waiting without a ready.
                to_hit = mv[owner] && !sr && (waited + 1 == TO);
                e_sv   = mv[owner] && !to_hit;
                e_sa   = ma[owner];
                e_sw   = mw[owner];
                e_swen = mwen[owner];
            end
            check_eq("s_valid", 64'(s_valid), 64'(e_sv));
            check_eq("s_addr",  64'(s_addr),  64'(e_sa));
            check_eq("s_wdata", 64'(s_wdata), 64'(e_sw));
            check_eq("s_wen",   64'(s_wen),   64'(e_swen));
            for (int m = 0; m < 2; m++) begin
                gr   = (owner == m);
                e_rd = !gr ? 32'h0 : (to_hit ? 32'hFFFF_FFFF : srd);
                check_eq($sformatf("m%0d_ready", m), 64'(mr[m]),  64'(gr && (sr || to_hit)));
                check_eq($sformatf("m%0d_err", m),   64'(me[m]),  64'(gr && to_hit));
                check_eq($sformatf("m%0d_rdata", m), 64'(mrd[m]), 64'(e_rd));
                done_m[m] = 1'b0;
            end
            if (i_rst) begin
                if (owner < 0) begin
                    if (since_rel >= 1) begin
                        if (mv[0] && mv[1])  owner = 1 - last_g;
                        else if (mv[0])      owner = 0;
                        else if (mv[1])      owner = 1;
                        waited = 0;
                    end
                    if (since_rel < 2) since_rel++;
                end else if (!mv[owner]) begin
                    owner = -1;
                end else if (sr || to_hit) begin
                    done_m[owner] = 1'b1;
                    $display("xfer m%0d addr=%08h wen=%h err=%0d rdata=%08h",
                             owner, ma[owner], mwen[owner], to_hit, to_hit ? 32'hFFFF_FFFF : srd);
                    last_g = owner;
                    owner  = -1;
                end else begin
                    waited++;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int exp_code [9];
        int got_code;
        bit act [2];

        i_rst = 1'b0;
        sr = 1'b0; srd = '0;
        for (int m = 0; m < 2; m++) begin
            mv[m] = 1'b0; ma[m] = '0; mw[m] = '0; mwen[m] = '0; act[m] = 1'b0;
        end

        // Reset: outputs stay zero even with a request and slave ready.
        tick();
        mv[0] = 1'b1; ma[0] = 32'h8000_0100; sr = 1'b1; srd = 32'h5555_AAAA;
        #2;
        check_eq("rst_s_valid",  64'(s_valid), 64'h0);
        check_eq("rst_s_addr",   64'(s_addr),  64'h0);
        check_eq("rst_m0_ready", 64'(mr[0]),   64'h0);
        check_eq("rst_m0_rdata", 64'(mrd[0]),  64'h0);
        tick();
        // Release; first grant not before the second edge.
        i_rst = 1'b1; sr = 1'b0;
        #2 check_eq("rel_cyc0_s_valid", 64'(s_valid), 64'h0);
        tick();
        #2 check_eq("rel_cyc1_s_valid", 64'(s_valid), 64'h0);
        tick();
        sr = 1'b1; srd = 32'h1111_2222;
        #2;
        check_eq("rel_cyc2_s_valid", 64'(s_valid), 64'h1);
        check_eq("rel_cyc2_m0_ready", 64'(mr[0]), 64'h1);
        check_eq("rel_cyc2_m0_rdata", 64'(mrd[0]), 64'h1111_2222);
        tick(); mv[0] = 1'b0; sr = 1'b0;
        tick();

        // Single master read, two wait cycles.
        tick();
        mv[0] = 1'b1; ma[0] = 32'h8000_0010; mw[0] = '0; mwen[0] = 4'h0;
        #2 check_eq("rd_idle_s_valid", 64'(s_valid), 64'h0);
        tick();
        #2;
        check_eq("rd_w1_s_valid", 64'(s_valid), 64'h1);
        check_eq("rd_w1_s_addr",  64'(s_addr),  64'h8000_0010);
        check_eq("rd_w1_m0_ready", 64'(mr[0]), 64'h0);
        tick();
        #2 check_eq("rd_w2_m0_ready", 64'(mr[0]), 64'h0);
        tick();
        sr = 1'b1; srd = 32'hDEAD_BEEF;
        #2;
        check_eq("rd_done_m0_ready", 64'(mr[0]), 64'h1);
        check_eq("rd_done_m0_rdata", 64'(mrd[0]), 64'hDEAD_BEEF);
        check_eq("rd_done_m0_err",   64'(me[0]), 64'h0);
        tick(); mv[0] = 1'b0; sr = 1'b0;
        tick();

        // Write pass-through from m1; m0 fields must never reach the slave.
        tick();
        mv[1] = 1'b1; ma[1] = 32'h8000_0004; mw[1] = 32'h1234_5678; mwen[1] = 4'b0011;
        ma[0] = 32'hAAAA_AAAA; mw[0] = 32'hBBBB_BBBB; mwen[0] = 4'hF;
        #2;
        check_eq("wr_idle_s_addr",  64'(s_addr),  64'h0);
        check_eq("wr_idle_s_wdata", 64'(s_wdata), 64'h0);
        check_eq("wr_idle_s_wen",   64'(s_wen),   64'h0);
        tick();
        #2;
        check_eq("wr_g1_s_valid", 64'(s_valid), 64'h1);
        check_eq("wr_g1_s_addr",  64'(s_addr),  64'h8000_0004);
        check_eq("wr_g1_s_wdata", 64'(s_wdata), 64'h1234_5678);
        check_eq("wr_g1_s_wen",   64'(s_wen),   64'h3);
        check_eq("wr_g1_m0_ready", 64'(mr[0]), 64'h0);
        tick();
        sr = 1'b1;
        #2;
        check_eq("wr_done_m1_ready", 64'(mr[1]), 64'h1);
        check_eq("wr_done_m0_ready", 64'(mr[0]), 64'h0);
        tick(); mv[1] = 1'b0; sr = 1'b0;
        #2 check_eq("wr_after_s_wdata", 64'(s_wdata), 64'h0);
        tick();

        // Timeout: slave never ready, abort on the 4th wait cycle.
        tick();
        mv[0] = 1'b1; ma[0] = 32'h8000_0020;
        tick();
        for (int w = 1; w < TO; w++) begin
            #2 check_eq($sformatf("to_w%0d_m0_ready", w), 64'(mr[0]), 64'h0);
            tick();
        end
        #2;
        check_eq("to_m0_ready", 64'(mr[0]),  64'h1);
        check_eq("to_m0_err",   64'(me[0]),  64'h1);
        check_eq("to_m0_rdata", 64'(mrd[0]), 64'hFFFF_FFFF);
        check_eq("to_s_valid",  64'(s_valid), 64'h0);
        tick();
        #2;
        check_eq("to_next_s_valid",  64'(s_valid), 64'h0);
        check_eq("to_next_m0_ready", 64'(mr[0]),   64'h0);
        tick(); mv[0] = 1'b0;
        tick();

        // Ready coincides with the timeout cycle: normal completion.
        tick();
        mv[0] = 1'b1; ma[0] = 32'h8000_0030;
        tick(); tick(); tick(); tick();
        sr = 1'b1; srd = 32'h0BAD_F00D;
        #2;
        check_eq("rt_m0_ready", 64'(mr[0]),  64'h1);
        check_eq("rt_m0_err",   64'(me[0]),  64'h0);
        check_eq("rt_m0_rdata", 64'(mrd[0]), 64'h0BAD_F00D);
        tick(); mv[0] = 1'b0; sr = 1'b0;
        tick();

        // Reset mid-transfer: s_valid drops without a clock edge.
        tick();
        mv[0] = 1'b1; ma[0] = 32'h8000_0040;
        tick();
        #2 check_eq("mr_pre_s_valid", 64'(s_valid), 64'h1);
        i_rst = 1'b0; sr = 1'b1; mv[1] = 1'b1; ma[1] = 32'h8000_0044;
        #1;
        check_eq("mr_async_s_valid",  64'(s_valid), 64'h0);
        check_eq("mr_async_m0_ready", 64'(mr[0]),   64'h0);
        tick(); tick();

        // Contention from release with an always-ready slave:
        // idle, idle, m0, idle, m1, idle, m0, idle, m1.
        exp_code = '{0, 0, 1, 0, 2, 0, 1, 0, 2};
        i_rst = 1'b1;
        for (int k = 0; k < 9; k++) begin
            if (k > 0) tick();
            #2;
            got_code = mr[0] ? 1 : (mr[1] ? 2 : 0);
            check_eq($sformatf("rr_cyc%0d", k), 64'(got_code), 64'(exp_code[k]));
        end
        tick(); mv[0] = 1'b0; mv[1] = 1'b0; sr = 1'b0;
        tick(); tick();

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            tick();
            for (int m = 0; m < 2; m++) begin
                if (act[m] && done_m[m]) begin
                    act[m] = 1'b0;
                end else if (act[m] && $urandom_range(0, 49) == 0) begin
                    act[m] = 1'b0;
                end else if (!act[m] && $urandom_range(0, 2) == 0) begin
                    act[m]  = 1'b1;
                    ma[m]   = $urandom;
                    mw[m]   = $urandom;
                    mwen[m] = 4'($urandom_range(0, 15));
                end
                mv[m] = act[m];
            end
            sr  = ($urandom_range(0, 2) == 0);
            srd = $urandom;
        end
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
